// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: immediate formats (EXTOp),
// ALU operations (ALUOp), next-PC selects (NPCOp), write-data selects (WDSel),
// FSM state and instruction-class encodings, error codes and the R/I funct3 ALU map.
package mc_ctrl_pkg;

  // Immediate formats, one-hot
  localparam logic [5:0] EXT_NONE        = 6'b000000;
  localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_JTYPE       = 6'b000001;

  // ALU operations
  localparam logic [4:0] ALU_LUI  = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_BNE  = 5'b00101;
  localparam logic [4:0] ALU_BLT  = 5'b00110;
  localparam logic [4:0] ALU_BGE  = 5'b00111;
  localparam logic [4:0] ALU_BLTU = 5'b01000;
  localparam logic [4:0] ALU_BGEU = 5'b01001;
  localparam logic [4:0] ALU_SLT  = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011;
  localparam logic [4:0] ALU_XOR  = 5'b01100;
  localparam logic [4:0] ALU_OR   = 5'b01101;
  localparam logic [4:0] ALU_AND  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b01111;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b10001;

  // Next-PC selects
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  // Register-file write-data selects
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  // Opcodes
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_RALU  = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    C_LUI   = 3'd0,
    C_RALU  = 3'd1,
    C_IALU  = 3'd2,
    C_LOAD  = 3'd3,
    C_STORE = 3'd4,
    C_BR    = 3'd5,
    C_JAL   = 3'd6,
    C_JALR  = 3'd7
  } cls_e;

  // funct3 -> ALU op for register/immediate arithmetic; alt selects sub/sra
  function automatic logic [4:0] alu_of_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of_f3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of_f3 = ALU_SLL;
      3'b010:  alu_of_f3 = ALU_SLT;
      3'b011:  alu_of_f3 = ALU_SLTU;
      3'b100:  alu_of_f3 = ALU_XOR;
      3'b101:  alu_of_f3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of_f3 = ALU_OR;
      default: alu_of_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier for the supported RV32I subset.
// Ports: Op/Funct7/Funct3 from IR in; cls (instruction class), illegal,
// ALUOp and EXTOp for the class out. No state, no latency.
module mc_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] Op,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  output cls_e       cls,
  output logic       illegal,
  output logic [4:0] ALUOp,
  output logic [5:0] EXTOp
);

  logic f7_zero;
  logic f7_alt;

  assign f7_zero = (Funct7 == 7'b0000000);
  assign f7_alt  = (Funct7 == 7'b0100000);

  always_comb begin
    cls     = C_LUI;
    illegal = 1'b0;
    ALUOp   = ALU_ADD;
    EXTOp   = EXT_NONE;
    case (Op)
      OP_LUI: begin
        cls   = C_LUI;
        ALUOp = ALU_LUI;
        EXTOp = EXT_UTYPE;
      end
      OP_RALU: begin
        cls     = C_RALU;
        ALUOp   = alu_of_f3(Funct3, Funct7[5]);
        // only add/sub and srl/sra have an alternate funct7
        illegal = !(f7_zero || (f7_alt && (Funct3 == 3'b000 || Funct3 == 3'b101)));
      end
      OP_IALU: begin
        cls   = C_IALU;
        EXTOp = EXT_ITYPE;
        ALUOp = alu_of_f3(Funct3, 1'b0);
        if (Funct3 == 3'b001) begin
          EXTOp   = EXT_ITYPE_SHAMT;
          illegal = !f7_zero;
        end else if (Funct3 == 3'b101) begin
          EXTOp   = EXT_ITYPE_SHAMT;
          ALUOp   = alu_of_f3(Funct3, f7_alt);
          illegal = !(f7_zero || f7_alt);
        end
      end
      OP_LOAD: begin
        cls     = C_LOAD;
        EXTOp   = EXT_ITYPE;
        illegal = (Funct3 != 3'b010);
      end
      OP_STORE: begin
        cls     = C_STORE;
        EXTOp   = EXT_STYPE;
        illegal = (Funct3 != 3'b010);
      end
      OP_BR: begin
        cls   = C_BR;
        EXTOp = EXT_BTYPE;
        case (Funct3)
          3'b000:  ALUOp = ALU_SUB;
          3'b001:  ALUOp = ALU_BNE;
          3'b100:  ALUOp = ALU_BLT;
          3'b101:  ALUOp = ALU_BGE;
          3'b110:  ALUOp = ALU_BLTU;
          3'b111:  ALUOp = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        cls   = C_JAL;
        EXTOp = EXT_JTYPE;
      end
      OP_JALR: begin
        cls     = C_JALR;
        EXTOp   = EXT_ITYPE;
        illegal = (Funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory req/ack
// with timeout, sticky trap and retired-instruction counter.
// Ports: Op/Funct7/Funct3/Zero/mem_ack in; datapath strobes and selects,
// mem_req, debug state, halted, err_code and instret out.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             ALUSrc,
  output logic [5:0]       EXTOp,
  output logic [4:0]       ALUOp,
  output logic [2:0]       NPCOp,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  logic [4:0]         alu_q, alu_d;
  logic [5:0]         ext_q, ext_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  cls_e               dec_cls;
  logic               dec_illegal;
  logic [4:0]         dec_alu;
  logic [5:0]         dec_ext;
  logic               waiting;
  logic               timeout;

  mc_dec u_dec (
    .Op      (Op),
    .Funct7  (Funct7),
    .Funct3  (Funct3),
    .cls     (dec_cls),
    .illegal (dec_illegal),
    .ALUOp   (dec_alu),
    .EXTOp   (dec_ext)
  );

  // A request is outstanding in FETCH and MEM; an ack on the limit cycle wins.
  assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ack;
  assign timeout = (TIMEOUT_CYC != 0) && waiting && (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_LUI;
      alu_q     <= '0;
      ext_q     <= '0;
      wait_q    <= '0;
      err_q     <= ERR_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      ext_q     <= ext_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    ext_d   = ext_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        alu_d = dec_alu;
        ext_d = dec_ext;
        if (dec_illegal) begin
          state_d = S_TRAP;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_BR) state_d = S_FETCH;
        else if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Counter restarts on every state change, so it is zero on entry to FETCH/MEM.
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + WAIT_W'(1);
    else                    wait_d = wait_q;

    instret_d = instret_q + CNT_W'(PCWrite);
  end

  // All strobes are forced low in the reset cycle, whatever state is held.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrc   = 1'b0;
    EXTOp    = EXT_NONE;
    ALUOp    = 5'b00000;
    NPCOp    = NPC_PLUS4;
    WDSel    = WD_ALU;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ack;
        end
        S_EXEC: begin
          ALUOp   = alu_q;
          EXTOp   = ext_q;
          ALUSrc  = cls_q inside {C_LUI, C_IALU, C_LOAD, C_STORE, C_JAL, C_JALR};
          ALUSrcA = (cls_q == C_JAL || cls_q == C_JALR);
          if (cls_q == C_BR) begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = (cls_q == C_STORE);
          PCWrite  = mem_ack && (cls_q == C_STORE);
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          case (cls_q)
            C_LOAD:  WDSel = WD_MEM;
            C_JAL:   WDSel = WD_PC;
            C_JALR:  WDSel = WD_PC;
            default: WDSel = WD_ALU;
          endcase
          case (cls_q)
            C_JAL:   NPCOp = NPC_JUMP;
            C_JALR:  NPCOp = NPC_JALR;
            default: NPCOp = NPC_PLUS4;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state    = rst ? 3'b000 : state_q;
  assign halted   = !rst && (state_q == S_TRAP);
  assign err_code = rst ? ERR_NONE : err_q;
  assign instret  = rst ? '0 : instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with TIMEOUT_CYC=4 and a 3-bit instret so the
// timeout limit and counter wrap are reachable in a short run.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       Zero;
  logic       mem_ack;
  logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrc;
  logic [5:0] EXTOp;
  logic [4:0] ALUOp;
  logic [2:0] NPCOp;
  logic [1:0] WDSel;
  logic [2:0] state;
  logic       halted;
  logic [1:0] err_code;
  logic [2:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT_CYC(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
    .Zero(Zero), .mem_ack(mem_ack), .mem_req(mem_req), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .WDSel(WDSel), .state(state),
    .halted(halted), .err_code(err_code), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the rising edge, sample mid-cycle.
  task automatic step(input logic r, input logic ack, input logic z);
    @(posedge clk);
    #1;
    rst = r; mem_ack = ack; Zero = z;
    #4;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    Op = ins[6:0]; Funct3 = ins[14:12]; Funct7 = ins[31:25];
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_SW   = 32'h0050A423;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_CUST = 32'h0000000B;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; Zero = 1'b0;
    set_instr(32'h0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("rst_state",   32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_halted",  32'(halted), 32'd0);
    chk("rst_err",     32'(err_code), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);

    // add: zero-wait, 4 cycles
    set_instr(I_ADD);
    step(0, 1, 0);
    chk("add_f_state", 32'(state), 32'd0);
    chk("add_f_req",   32'(mem_req), 32'd1);
    chk("add_f_iord",  32'(IorD), 32'd0);
    chk("add_f_irw",   32'(IRWrite), 32'd1);
    step(0, 0, 0);
    chk("add_d_state", 32'(state), 32'd1);
    chk("add_d_req",   32'(mem_req), 32'd0);
    step(0, 0, 0);
    chk("add_e_state",  32'(state), 32'd2);
    chk("add_e_aluop",  32'(ALUOp), 32'h03);
    chk("add_e_alusrc", 32'(ALUSrc), 32'd0);
    chk("add_e_pcw",    32'(PCWrite), 32'd0);
    step(0, 0, 0);
    chk("add_wb_state", 32'(state), 32'd4);
    chk("add_wb_regw",  32'(RegWrite), 32'd1);
    chk("add_wb_pcw",   32'(PCWrite), 32'd1);
    chk("add_wb_npc",   32'(NPCOp), 32'd0);
    chk("add_wb_wdsel", 32'(WDSel), 32'd0);
    chk("add_wb_instret", 32'(instret), 32'd0);

    // lw with two wait cycles in MEM: 7 cycles
    set_instr(I_LW);
    step(0, 1, 0);
    chk("lw_f_state",   32'(state), 32'd0);
    chk("lw_f_instret", 32'(instret), 32'd1);
    step(0, 0, 0);
    chk("lw_d_state", 32'(state), 32'd1);
    step(0, 0, 0);
    chk("lw_e_state",  32'(state), 32'd2);
    chk("lw_e_alusrc", 32'(ALUSrc), 32'd1);
    chk("lw_e_extop",  32'(EXTOp), 32'h10);
    chk("lw_e_aluop",  32'(ALUOp), 32'h03);
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 2), 0);
      chk("lw_m_state", 32'(state), 32'd3);
      chk("lw_m_iord",  32'(IorD), 32'd1);
      chk("lw_m_req",   32'(mem_req), 32'd1);
      chk("lw_m_memw",  32'(MemWrite), 32'd0);
      chk("lw_m_pcw",   32'(PCWrite), 32'd0);
    end
    step(0, 0, 0);
    chk("lw_wb_state", 32'(state), 32'd4);
    chk("lw_wb_wdsel", 32'(WDSel), 32'd1);
    chk("lw_wb_regw",  32'(RegWrite), 32'd1);
    chk("lw_wb_pcw",   32'(PCWrite), 32'd1);

    // beq taken, then not taken: 3 cycles each
    set_instr(I_BEQ);
    step(0, 1, 0);
    chk("beq1_f_state",   32'(state), 32'd0);
    chk("beq1_f_instret", 32'(instret), 32'd2);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("beq1_e_state", 32'(state), 32'd2);
    chk("beq1_e_pcw",   32'(PCWrite), 32'd1);
    chk("beq1_e_npc",   32'(NPCOp), 32'd1);
    chk("beq1_e_regw",  32'(RegWrite), 32'd0);
    chk("beq1_e_aluop", 32'(ALUOp), 32'h04);
    step(0, 1, 0);
    chk("beq2_f_state",   32'(state), 32'd0);
    chk("beq2_f_instret", 32'(instret), 32'd3);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("beq2_e_pcw",  32'(PCWrite), 32'd1);
    chk("beq2_e_npc",  32'(NPCOp), 32'd0);
    chk("beq2_e_regw", 32'(RegWrite), 32'd0);

    // sw: fetch ack arrives on the limit cycle (success), then rst mid-MEM
    set_instr(I_SW);
    for (int i = 0; i < 4; i++) begin
      step(0, (i == 3), 0);
      chk("sw_f_state", 32'(state), 32'd0);
      chk("sw_f_req",   32'(mem_req), 32'd1);
    end
    chk("sw_f_instret", 32'(instret), 32'd4);
    step(0, 0, 0);
    chk("sw_d_state", 32'(state), 32'd1);
    step(0, 0, 0);
    chk("sw_e_extop",  32'(EXTOp), 32'h08);
    chk("sw_e_alusrc", 32'(ALUSrc), 32'd1);
    step(0, 0, 0);
    chk("sw_m_state", 32'(state), 32'd3);
    chk("sw_m_memw",  32'(MemWrite), 32'd1);
    chk("sw_m_pcw",   32'(PCWrite), 32'd0);
    step(1, 1, 0);
    chk("sw_rst_memw", 32'(MemWrite), 32'd0);
    chk("sw_rst_pcw",  32'(PCWrite), 32'd0);
    chk("sw_rst_req",  32'(mem_req), 32'd0);
    step(0, 0, 0);
    chk("sw_post_state",   32'(state), 32'd0);
    chk("sw_post_instret", 32'(instret), 32'd0);

    // complete a store
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("sw2_m_state", 32'(state), 32'd3);
    chk("sw2_m_memw",  32'(MemWrite), 32'd1);
    chk("sw2_m_pcw",   32'(PCWrite), 32'd1);
    chk("sw2_m_npc",   32'(NPCOp), 32'd0);

    // jal
    set_instr(I_JAL);
    step(0, 1, 0);
    chk("jal_f_instret", 32'(instret), 32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("jal_e_state", 32'(state), 32'd2);
    chk("jal_e_srca",  32'(ALUSrcA), 32'd1);
    chk("jal_e_extop", 32'(EXTOp), 32'h01);
    step(0, 0, 0);
    chk("jal_wb_npc",   32'(NPCOp), 32'd2);
    chk("jal_wb_wdsel", 32'(WDSel), 32'd2);
    chk("jal_wb_regw",  32'(RegWrite), 32'd1);

    // six more retires wrap the 3-bit counter from 2 to 0
    set_instr(I_BEQ);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);
    end
    // first unacknowledged fetch cycle, then three more, then timeout
    step(0, 0, 0);
    chk("wrap_instret", 32'(instret), 32'd0);
    chk("to_req0",      32'(mem_req), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 0);
      chk("to_state", 32'(state), 32'd0);
      chk("to_req",   32'(mem_req), 32'd1);
    end
    step(0, 1, 0);
    chk("to_trap_state", 32'(state), 32'd7);
    chk("to_trap_err",   32'(err_code), 32'd2);
    chk("to_trap_halt",  32'(halted), 32'd1);
    chk("to_trap_req",   32'(mem_req), 32'd0);

    step(1, 0, 0);
    step(0, 0, 0);
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_err",    32'(err_code), 32'd0);

    // custom-0 opcode traps after DECODE
    set_instr(I_CUST);
    step(0, 1, 0);
    chk("ill_f_state", 32'(state), 32'd0);
    step(0, 0, 0);
    chk("ill_d_state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      chk("ill_trap_state", 32'(state), 32'd7);
      chk("ill_trap_err",   32'(err_code), 32'd1);
      chk("ill_trap_halt",  32'(halted), 32'd1);
      chk("ill_trap_req",   32'(mem_req), 32'd0);
      chk("ill_trap_irw",   32'(IRWrite), 32'd0);
    end
    step(1, 0, 0);
    step(0, 0, 0);
    chk("rst3_state", 32'(state), 32'd0);
    chk("rst3_err",   32'(err_code), 32'd0);
    chk("rst3_req",   32'(mem_req), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle controller for the RV32I subset datapath: lui, R-type ALU ops, I-type ALU ops, lw, sw, beq/bne/blt/bge/bltu/bgeu, jal, jalr.
- Sequences the shared PC/IR/ALU/register-file/memory datapath through FETCH→DECODE→EXEC→MEM→WB.
- Drives the existing EXTOp/ALUOp/NPCOp/WDSel encodings from ctrl_encode_def.v.
- Adds a single-port memory request/acknowledge handshake with a timeout, a sticky trap, and a retired-instruction counter.

Parameters:
- TIMEOUT_CYC, 16: max cycles to wait for mem_ack per request; 0 disables the timeout.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  7  opcode from IR
- Funct7  in  7  funct7 from IR
- Funct3  in  3  funct3 from IR
- Zero  in  1  ALU condition/zero flag
- mem_ack  in  1  memory done this cycle
- mem_req  out  1  memory access request
- IorD  out  1  memory address source: 0=PC, 1=ALUOut
- MemWrite  out  1  store strobe, qualified by mem_req
- IRWrite  out  1  load IR
- PCWrite  out  1  update PC using NPCOp
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0=rs1, 1=PC
- ALUSrc  out  1  ALU B from immediate
- EXTOp  out  6  immediate format (one-hot)
- ALUOp  out  5  ALU operation
- NPCOp  out  3  next-PC select
- WDSel  out  2  write-data select
- state  out  3  current state (debug)
- halted  out  1  sticky trap flag
- err_code  out  2  00 none, 01 illegal instruction, 10 memory timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst high → state=FETCH, class register cleared, wait counter=0, instret=0, halted=0, err_code=00. All outputs are 0 while rst is high. rst wins over every other event, including mid-MEM; no write strobe may be asserted in the rst cycle.
- Outputs are Moore decodes of state plus the class latched in DECODE. Zero is the only input sampled combinationally, and only in EXEC.
- FETCH (000): mem_req=1, IorD=0.
  - mem_ack=1 → IRWrite=1, go to DECODE.
  - Zero-wait ack on the first cycle is legal, giving FETCH 1 cycle.
- DECODE (001): classify Op/Funct3/Funct7 into class {LUI, RALU, IALU, LOAD, STORE, BR, JAL, JALR}, register it, go to EXEC.
  - Unsupported encoding → TRAP, err_code=01.
- EXEC (010): ALUSrc, EXTOp and ALUOp per class.
  - BR: ALUSrc=0, PCWrite=1, NPCOp=BRANCH if Zero else PLUS4, retire, go to FETCH.
  - LOAD/STORE: ALU computes the address, go to MEM.
  - Other classes: go to WB.
  - JAL/JALR: ALUSrcA=1 (PC).
- MEM (011): mem_req=1, IorD=1, MemWrite=(class==STORE).
  - On mem_ack: STORE → PCWrite=1, NPCOp=PLUS4, retire, go to FETCH; LOAD → go to WB.
- WB (100): RegWrite=1, PCWrite=1, retire, go to FETCH.
  - WDSel: MEM for LOAD, PC for JAL/JALR, ALU otherwise.
  - NPCOp: JUMP for JAL, JALR for JALR, PLUS4 otherwise.
- Latency with zero wait (cycles):
  - BR 3
  - STORE, RALU, IALU, LUI, JAL, JALR 4
  - LOAD 5
  - Each memory wait cycle adds 1.
- Retire: instret += 1 (wraps at 2^CNT_W) in exactly the cycle with PCWrite=1. PC is written exactly once per instruction.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle with mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYC with no ack → TRAP, err_code=10.
  - An ack in the same cycle the counter hits the limit counts as success.
- TRAP (111): all strobes 0, halted=1, err_code held. Sticky until rst.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package/include: add state encodings and class encodings next to the existing EXTOp/ALUOp/NPCOp/WDSel defines in ctrl_encode_def.v. Add no new ALU/NPC codes.
- One sub-module, mc_dec: purely combinational instruction classifier plus per-class ALUOp/EXTOp. Output is class[2:0], illegal, ALUOp, EXTOp.
- The FSM, wait counter and instret stay in mc_ctrl.

Test Plan:
- add x3,x1,x2 (0x002081B3), ack same cycle each request → states 000,001,010,100. RegWrite=1, PCWrite=1, NPCOp=000 in cycle 4. instret 0→1.
- lw x5,8(x1) (0x0080A283), 2 wait cycles in MEM → MEM held 3 cycles with IorD=1. WB has WDSel=01, RegWrite=1. Total 7 cycles.
- beq, Zero=1 then Zero=0 → EXEC has PCWrite=1 with NPCOp=001 then 000. No RegWrite. 3 cycles each.
- Op=0001011 (custom-0) → TRAP after DECODE, halted=1, err_code=01. No further mem_req until rst.
- TIMEOUT_CYC=4, never ack in FETCH → mem_req high for 4 cycles, then state=111, err_code=10.
- sw in MEM, rst pulsed before ack → next cycle state=000 and instret=0. MemWrite=0 during the rst cycle.
